// File: rtl/systolic_nxn_mac_pkg.sv
// Shared types and sizing helpers for the NxN output-stationary systolic MAC.
package systolic_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_e;

    localparam int N_DEFAULT = 4;
    localparam int DRAIN_LEN = 2 * N_DEFAULT - 1;

    function automatic int acc_width(input int data_w, input int k_max);
        return 2 * data_w + $clog2(k_max);
    endfunction

    // Last beat reaches the far corner PE 2N-2 hops after acceptance.
    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_nxn_mac_if.sv
// Operand stream, job control and row-serial result port of the systolic MAC.
interface systolic_nxn_mac_if import systolic_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int K_MAX  = 256,
    parameter int ACC_W  = acc_width(DATA_W, K_MAX)
);
    logic                          start;
    logic [$clog2(K_MAX+1)-1:0]    k_len;
    logic                          acc_keep;
    logic                          in_valid;
    logic                          in_ready;
    logic [N-1:0][DATA_W-1:0]      a_vec;
    logic [N-1:0][DATA_W-1:0]      b_vec;
    logic                          out_valid;
    logic                          out_ready;
    logic [N-1:0][ACC_W-1:0]       out_row;
    logic [$clog2(N)-1:0]          out_idx;
    logic                          out_last;
    logic                          busy;
    logic                          done;

    modport master (
        output start, k_len, acc_keep, in_valid, a_vec, b_vec, out_ready,
        input  in_ready, out_valid, out_row, out_idx, out_last, busy, done
    );

    modport slave (
        input  start, k_len, acc_keep, in_valid, a_vec, b_vec, out_ready,
        output in_ready, out_valid, out_row, out_idx, out_last, busy, done
    );
endinterface

// File: rtl/systolic_nxn_mac_pe_acc.sv
// One processing element: forwards a right / b down with a 1-cycle hop and
// accumulates a*b whenever the travelling valid tag is set.
module systolic_pe_acc #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              v_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              v_out,
    output logic [ACC_W-1:0]  acc
);
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic                v_q, v_d;
    logic [ACC_W-1:0]    acc_q, acc_d, prod_ext;
    logic [2*DATA_W-1:0] prod;
    logic                ext;

    always_comb begin
        // Low 2*DATA_W bits of the extended-operand product equal the signed product.
        if (SIGNED != 0)
            prod = {{DATA_W{a_in[DATA_W-1]}}, a_in} * {{DATA_W{b_in[DATA_W-1]}}, b_in};
        else
            prod = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
        ext      = (SIGNED != 0) ? prod[2*DATA_W-1] : 1'b0;
        prod_ext = {{(ACC_W-2*DATA_W){ext}}, prod};
        a_d   = a_in;
        b_d   = b_in;
        v_d   = v_in;
        acc_d = acc_q;
        if (clr)       acc_d = '0;
        else if (v_in) acc_d = acc_q + prod_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            v_q   <= 1'b0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            v_q   <= v_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign v_out = v_q;
    assign acc   = acc_q;
endmodule

// File: rtl/systolic_nxn_mac.sv
// NxN output-stationary matmul engine: skews unskewed operand vectors into a
// PE grid, drains the wavefront, then streams result rows out with backpressure.
module systolic_nxn_mac import systolic_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int K_MAX  = 256,
    parameter int SIGNED = 1,
    parameter int ACC_W  = acc_width(DATA_W, K_MAX)
) (
    input logic clk,
    input logic rst,
    systolic_nxn_mac_if.slave io
);
    localparam int KW        = $clog2(K_MAX + 1);
    localparam int RW        = $clog2(N);
    localparam int DRAIN_CYC = drain_len(N);
    localparam int DW        = $clog2(DRAIN_CYC);

    state_e          state_q, state_d;
    logic [KW-1:0]   klen_q, klen_d, kcnt_q, kcnt_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic            done_q, done_d;
    logic            clr, accept;

    assign accept = (state_q == LOAD) && io.in_valid;

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        kcnt_d  = kcnt_q;
        dcnt_d  = dcnt_q;
        row_d   = row_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (io.start) begin
                klen_d  = io.k_len;
                kcnt_d  = '0;
                row_d   = '0;
                clr     = !io.acc_keep;
                state_d = (io.k_len == '0) ? OUT : LOAD;
            end
            LOAD: if (accept) begin
                kcnt_d = kcnt_q + 1'b1;
                if (kcnt_q + 1'b1 == klen_q) begin
                    dcnt_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == DW'(DRAIN_CYC - 1)) state_d = OUT;
            end
            OUT: if (io.out_ready) begin
                if (row_q == RW'(N - 1)) begin
                    row_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            klen_q  <= '0;
            kcnt_q  <= '0;
            dcnt_q  <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            kcnt_q  <= kcnt_d;
            dcnt_q  <= dcnt_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    // Lane i of A / lane j of B delayed i / j cycles; the valid tag rides with A.
    logic [N-1:0][DATA_W-1:0] a_sk, b_sk;
    logic [N-1:0]             v_sk;

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_sk[i] = io.a_vec[i];
            assign b_sk[i] = io.b_vec[i];
            assign v_sk[i] = accept;
        end else begin : g_delay
            logic [i-1:0][DATA_W:0]   av_q, av_d;
            logic [i-1:0][DATA_W-1:0] bs_q, bs_d;
            always_comb begin
                av_d[0] = {accept, io.a_vec[i]};
                bs_d[0] = io.b_vec[i];
                for (int s = 1; s < i; s++) begin
                    av_d[s] = av_q[s-1];
                    bs_d[s] = bs_q[s-1];
                end
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    av_q <= '0;
                    bs_q <= '0;
                end else begin
                    av_q <= av_d;
                    bs_q <= bs_d;
                end
            end
            assign {v_sk[i], a_sk[i]} = av_q[i-1];
            assign b_sk[i]            = bs_q[i-1];
        end
    end

    logic [N-1:0][N-1:0][DATA_W-1:0] a_h, b_h;
    logic [N-1:0][N-1:0]             v_h;
    logic [N-1:0][N-1:0][ACC_W-1:0]  acc;

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DATA_W-1:0] a_i, b_i;
            logic              v_i;
            if (j == 0) begin : g_a_edge
                assign a_i = a_sk[i];
                assign v_i = v_sk[i];
            end else begin : g_a_hop
                assign a_i = a_h[i][j-1];
                assign v_i = v_h[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_i = b_sk[j];
            end else begin : g_b_hop
                assign b_i = b_h[i-1][j];
            end
            systolic_pe_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_pe (
                .clk(clk), .rst(rst), .clr(clr),
                .a_in(a_i), .b_in(b_i), .v_in(v_i),
                .a_out(a_h[i][j]), .b_out(b_h[i][j]), .v_out(v_h[i][j]),
                .acc(acc[i][j])
            );
        end
        logic edge_unused;
        assign edge_unused = ^{a_h[i][N-1], v_h[i][N-1], b_h[N-1][i]};
    end

    assign io.in_ready  = (state_q == LOAD);
    assign io.out_valid = (state_q == OUT);
    assign io.out_row   = (state_q == OUT) ? acc[row_q] : '0;
    assign io.out_idx   = row_q;
    assign io.out_last  = (state_q == OUT) && (row_q == RW'(N - 1));
    assign io.busy      = (state_q != IDLE);
    assign io.done      = done_q;
endmodule

// File: tb/tb_systolic_nxn_mac.sv
// Randomized + directed bench for systolic_nxn_mac against a plain matrix-product model.
module tb_systolic_nxn_mac;
    import systolic_pkg::*;

    localparam int DATA_W = 8;
    localparam int N      = 2;
    localparam int K_MAX  = 256;
    localparam int SIGNED = 1;
    localparam int ACC_W  = acc_width(DATA_W, K_MAX);
    localparam int KW     = $clog2(K_MAX + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_nxn_mac_if #(.DATA_W(DATA_W), .N(N), .K_MAX(K_MAX), .ACC_W(ACC_W)) bus ();

    systolic_nxn_mac #(.DATA_W(DATA_W), .N(N), .K_MAX(K_MAX), .SIGNED(SIGNED), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .io(bus)
    );

    logic [DATA_W-1:0] ma [N][K_MAX];
    logic [DATA_W-1:0] mb [K_MAX][N];
    logic [ACC_W-1:0]  exp_c [N][N];
    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // C = (keep ? C : 0) + A*B, wrapped to ACC_W bits.
    task automatic model_job(input int klen, input bit keep);
        longint sum;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                sum = keep ? longint'(exp_c[i][j]) : 64'sd0;
                for (int t = 0; t < klen; t++)
                    sum += longint'($signed(ma[i][t])) * longint'($signed(mb[t][j]));
                exp_c[i][j] = sum[ACC_W-1:0];
            end
    endtask

    task automatic fill_case1();
        ma[0][0] = 8'd1; ma[0][1] = 8'd2; ma[1][0] = 8'd3; ma[1][1] = 8'd4;
        mb[0][0] = 8'd5; mb[0][1] = 8'd6; mb[1][0] = 8'd7; mb[1][1] = 8'd8;
    endtask

    task automatic rand_fill(input int klen);
        for (int t = 0; t < klen; t++)
            for (int i = 0; i < N; i++) begin
                ma[i][t] = DATA_W'($urandom);
                mb[t][i] = DATA_W'($urandom);
            end
    endtask

    task automatic drive_beat(input int t, input bit v);
        bus.in_valid = v;
        for (int i = 0; i < N; i++) begin
            bus.a_vec[i] = ma[i][t];
            bus.b_vec[i] = mb[t][i];
        end
    endtask

    // gmode: 0 back-to-back, 1 random gaps, 2 pattern 1,0,0,1,...
    task automatic run_job(input int klen, input bit keep, input int gmode, input bit bp, input int hold);
        int t, r, cyc;
        bit v, rdy;
        model_job(klen, keep);
        bus.start = 1'b1; bus.k_len = KW'(klen); bus.acc_keep = keep;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_start", bus.busy, 1);
        t = 0; cyc = 0;
        while (t < klen && cyc < 8 * K_MAX) begin
            case (gmode)
                1:       v = ($urandom_range(0, 2) != 0);
                2:       v = (cyc % 3 == 0);
                default: v = 1'b1;
            endcase
            drive_beat(t, v);
            chk("in_ready_load", bus.in_ready, 1);
            @(posedge clk); #1;
            if (v) t++;
            cyc++;
        end
        if (t < klen) chk("load_timeout", t, klen);
        // Beats and start requests outside IDLE/LOAD must be ignored.
        bus.in_valid = 1'b1; bus.start = 1'b1; bus.k_len = '0;
        for (int i = 0; i < N; i++) begin
            bus.a_vec[i] = DATA_W'($urandom);
            bus.b_vec[i] = DATA_W'($urandom);
        end
        cyc = 0;
        while (!bus.out_valid && cyc < 4 * N + 4) begin
            chk("in_ready_drain", bus.in_ready, 0);
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0; bus.start = 1'b0;
        chk("drain_len", cyc, (klen > 0) ? 2 * N - 1 : 0);
        r = 0; cyc = 0;
        while (r < N && cyc < 200) begin
            rdy = (cyc < hold) ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
            bus.out_ready = rdy;
            chk("out_valid", bus.out_valid, 1);
            chk("in_ready_out", bus.in_ready, 0);
            chk("out_idx", bus.out_idx, r);
            chk("out_last", bus.out_last, (r == N - 1));
            for (int j = 0; j < N; j++) chk("out_row", bus.out_row[j], exp_c[r][j]);
            @(posedge clk); #1;
            if (rdy) r++;
            cyc++;
        end
        if (r < N) chk("out_timeout", r, N);
        bus.out_ready = 1'b0;
        chk("done_pulse", bus.done, 1);
        chk("busy_end", bus.busy, 0);
        chk("out_valid_end", bus.out_valid, 0);
        @(posedge clk); #1;
        chk("done_clear", bus.done, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_row"}, bus.out_row, 0);
        chk({tag, "_out_idx"}, bus.out_idx, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.k_len = '0; bus.acc_keep = 1'b0; bus.in_valid = 1'b0;
        bus.a_vec = '0; bus.b_vec = '0; bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_c[i][j] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic job, gapped job, accumulate chaining, backpressure hold.
        fill_case1();
        run_job(2, 1'b0, 0, 1'b0, 0);
        run_job(2, 1'b0, 2, 1'b0, 0);
        run_job(2, 1'b0, 0, 1'b0, 0);
        run_job(2, 1'b1, 0, 1'b0, 0);
        run_job(2, 1'b0, 0, 1'b0, 0);
        run_job(2, 1'b0, 0, 1'b0, 5);

        // Async reset in the middle of DRAIN.
        bus.start = 1'b1; bus.k_len = KW'(2); bus.acc_keep = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        drive_beat(0, 1'b1); @(posedge clk); #1;
        drive_beat(1, 1'b1); @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_drain_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_c[i][j] = '0;
        // acc_keep=1 here relies on reset having zeroed the accumulators.
        ma[0][0] = 8'd2; ma[1][0] = 8'hFD; mb[0][0] = 8'd4; mb[0][1] = 8'd5;
        run_job(1, 1'b1, 0, 1'b0, 0);

        // Empty job clears; full-length job at the most negative operand.
        run_job(0, 1'b0, 0, 1'b0, 0);
        for (int t = 0; t < K_MAX; t++)
            for (int i = 0; i < N; i++) begin
                ma[i][t] = 8'h80;
                mb[t][i] = 8'h80;
            end
        run_job(K_MAX, 1'b0, 0, 1'b0, 0);

        for (int n = 0; n < 24; n++) begin
            int klen;
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b1; bus.out_ready = 1'b1;
                @(posedge clk); #1;
                chk("idle_ignore", bus.busy, 0);
            end
            bus.in_valid = 1'b0; bus.out_ready = 1'b0;
            klen = $urandom_range(1, 10);
            rand_fill(klen);
            run_job(klen, 1'($urandom_range(0, 1)), 1, 1'b1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
